// File: rtl/mul_issue_ctrl.sv
// EX-stage control around a 2-stage multiplier: operand extension, result word selection,
// and a 2-entry result FIFO with credit-based acceptance toward MEM.
module mul_issue_ctrl #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [33:0]      mul_x,
    output logic [33:0]      mul_y,
    input  logic [67:0]      mul_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    logic             op_signed;
    logic             fire;
    logic             push;
    logic             pop;
    logic [31:0]      p1_res;
    logic             unused_bits;

    logic             p1_valid_q;
    logic             p1_hi_q;
    logic [TAG_W-1:0] p1_tag_q;
    logic [1:0]       count_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [31:0]      fifo_res_q [2];
    logic [TAG_W-1:0] fifo_tag_q [2];

    always_comb begin
        op_signed = ~in_op[2];
        mul_x     = {{2{op_signed & in_src1[31]}}, in_src1};
        mul_y     = {{2{op_signed & in_src2[31]}}, in_src2};
    end

    assign out_valid  = (count_q != 2'd0);
    assign pop        = out_valid & out_ready;
    // Credit counts the op in P1 so it always has a FIFO slot when it lands.
    assign in_ready   = (({1'b0, p1_valid_q} + count_q - {1'b0, pop}) < 2'd2);
    assign fire       = in_valid & in_ready & ~flush;
    assign push       = p1_valid_q;
    assign p1_res     = p1_hi_q ? mul_z[63:32] : mul_z[31:0];
    assign out_result = fifo_res_q[rd_ptr_q];
    assign out_tag    = fifo_tag_q[rd_ptr_q];

    assign unused_bits = ^{mul_z[67:64], in_op[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_valid_q <= 1'b0;
            p1_hi_q    <= 1'b0;
            p1_tag_q   <= '0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_res_q[i] <= '0;
                fifo_tag_q[i] <= '0;
            end
        end else if (flush) begin
            p1_valid_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            p1_valid_q <= fire;
            if (fire) begin
                p1_hi_q  <= in_op[1] | in_op[2];
                p1_tag_q <= in_tag;
            end
            if (push) begin
                fifo_res_q[wr_ptr_q] <= p1_res;
                fifo_tag_q[wr_ptr_q] <= p1_tag_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: external multiplier model, queue-based reference of accepted ops,
// directed scenarios followed by randomized traffic.
module tb_mul_issue_ctrl;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'b001;
    logic [31:0]      in_src1 = '0;
    logic [31:0]      in_src2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [33:0]      mul_x;
    logic [33:0]      mul_y;
    logic [67:0]      mul_z;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    int vectors = 0;
    int miscompares = 0;

    mul_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .in_tag    (in_tag),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_z     (mul_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // External 2-stage multiplier: product registered one clock after operands.
    always_ff @(posedge clk) mul_z <= 68'($signed(mul_x) * $signed(mul_y));

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } op_t;

    op_t q[$];
    int  cyc = 0;

    logic             exp_in_ready, exp_out_valid, exp_pop, exp_fire;
    logic [31:0]      exp_res;
    logic [TAG_W-1:0] exp_tag;
    logic             act_in_ready, act_out_valid;
    logic [31:0]      act_res;
    logic [TAG_W-1:0] act_tag;
    logic [33:0]      act_mul_x, act_mul_y;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        if (op[0]) return up[31:0];
        if (op[1]) return sp[63:32];
        return up[63:32];
    endfunction

    // One clock: drive inputs, sample at negedge, advance the reference at posedge.
    task automatic run_cycle(input logic v, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [TAG_W-1:0] tg,
                             input logic rdy, input logic fl, input logic rs);
        op_t e;
        in_valid = v; in_op = op; in_src1 = a; in_src2 = b; in_tag = tg;
        out_ready = rdy; flush = fl; reset = rs;
        @(negedge clk);
        exp_out_valid = (q.size() != 0) && (q[0].cyc + 2 <= cyc);
        exp_pop       = exp_out_valid & rdy;
        exp_in_ready  = (q.size() - (exp_pop ? 1 : 0)) < 2;
        exp_fire      = v & exp_in_ready & ~fl;
        exp_res       = (q.size() != 0) ? q[0].res : '0;
        exp_tag       = (q.size() != 0) ? q[0].tag : '0;
        act_in_ready  = in_ready;
        act_out_valid = out_valid;
        act_res       = out_result;
        act_tag       = out_tag;
        act_mul_x     = mul_x;
        act_mul_y     = mul_y;
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_fire) begin
                e.res = ref_result(op, a, b);
                e.tag = tg;
                e.cyc = cyc;
                q.push_back(e);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input logic rdy);
        run_cycle(1'b0, 3'b001, 32'd0, 32'd0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        run_cycle(1'b0, 3'b001, 32'd0, 32'd0, '0, 1'b1, 1'b0, 1'b1);
        run_cycle(1'b0, 3'b001, 32'd0, 32'd0, '0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        vectors++;
        if (act_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b want 0", act_out_valid);
        end
        vectors++;
        if (act_in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 1", act_in_ready);
        end
        vectors++;
        if (act_res !== 32'd0 || act_tag !== '0) begin
            miscompares++; $display("FAIL reset_data: got %h/%h want 0/0", act_res, act_tag);
        end
    endtask

    task automatic test_latency();
        run_cycle(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        vectors++;
        if (act_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL latency_early: got %b want 0", act_out_valid);
        end
        idle(1'b1);
        vectors++;
        if (act_out_valid !== 1'b1 || act_res !== 32'hFFFF_FFFE || act_tag !== 5'd5) begin
            miscompares++;
            $display("FAIL latency_mulw: got v=%b %h/%h want v=1 fffffffe/05",
                     act_out_valid, act_res, act_tag);
        end
        idle(1'b1);
    endtask

    task automatic test_mulh();
        logic [31:0] want [3];
        int k;
        want[0] = 32'h4000_0000; want[1] = 32'hFFFF_FFFE; want[2] = 32'h0000_0000;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: run_cycle(1'b1, 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1, 1'b0, 1'b0);
                1: run_cycle(1'b1, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0, 1'b0);
                2: run_cycle(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b0, 1'b0);
                default: idle(1'b1);
            endcase
            if (act_out_valid && k < 3) begin
                vectors++;
                if (act_res !== want[k]) begin
                    miscompares++;
                    $display("FAIL mulh_%0d: got %h want %h", k, act_res, want[k]);
                end
                k++;
            end
        end
        vectors++;
        if (k != 3) begin
            miscompares++; $display("FAIL mulh_count: got %0d want 3", k);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3];
        ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b100;
        for (int i = 0; i < 11; i++) begin
            if (i < 8)
                run_cycle(1'b1, ops[$urandom_range(0, 2)], $urandom, $urandom, 5'(i),
                          1'b1, 1'b0, 1'b0);
            else
                idle(1'b1);
            if (i < 8) begin
                vectors++;
                if (act_in_ready !== 1'b1) begin
                    miscompares++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, act_in_ready);
                end
            end
            if (i >= 2 && i < 10) begin
                vectors++;
                if (act_out_valid !== 1'b1 || act_tag !== 5'(i - 2) || act_res !== exp_res) begin
                    miscompares++;
                    $display("FAIL b2b_result[%0d]: got v=%b %h/%h want v=1 %h/%h", i,
                             act_out_valid, act_res, act_tag, exp_res, 5'(i - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic want_rdy [3];
        want_rdy[0] = 1'b1; want_rdy[1] = 1'b1; want_rdy[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 3'b001, 32'(i + 3), 32'd7, 5'(10 + i), 1'b0, 1'b0, 1'b0);
            vectors++;
            if (act_in_ready !== want_rdy[i]) begin
                miscompares++;
                $display("FAIL bp_accept[%0d]: got %b want %b", i, act_in_ready, want_rdy[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            vectors++;
            if (act_out_valid !== 1'b1 || act_tag !== 5'd10 || act_res !== 32'd21 ||
                act_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b %h/%h want v=1 rdy=0 15/0a", i,
                         act_out_valid, act_in_ready, act_res, act_tag);
            end
        end
        for (int i = 0; i < 2; i++) begin
            idle(1'b1);
            vectors++;
            if (act_out_valid !== 1'b1 || act_tag !== 5'(10 + i) || act_in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: got v=%b rdy=%b tag=%h want v=1 rdy=1 tag=%h", i,
                         act_out_valid, act_in_ready, act_tag, 5'(10 + i));
            end
        end
        idle(1'b1);
        vectors++;
        if (act_out_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_empty: got %b want 0", act_out_valid);
        end
    endtask

    task automatic test_flush();
        run_cycle(1'b1, 3'b001, 32'd2, 32'd3, 5'd1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        run_cycle(1'b1, 3'b001, 32'd4, 32'd5, 5'd2, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 3'b001, 32'd6, 32'd7, 5'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            vectors++;
            if (act_out_valid !== 1'b0 || act_in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL flush[%0d]: got v=%b rdy=%b want v=0 rdy=1", i,
                         act_out_valid, act_in_ready);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] a, b;
        run_cycle(1'b1, 3'b010, 32'd9, 32'd9, 5'd4, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 3'b010, 32'd8, 32'd8, 5'd5, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 3'b001, 32'd0, 32'd0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        vectors++;
        if (act_out_valid !== 1'b0 || act_res !== 32'd0 || act_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid: got v=%b rdy=%b res=%h want v=0 rdy=1 res=0",
                     act_out_valid, act_in_ready, act_res);
        end
        a = $urandom; b = $urandom;
        run_cycle(1'b1, 3'b100, a, b, 5'd17, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        vectors++;
        if (act_out_valid !== 1'b1 || act_res !== ref_result(3'b100, a, b) ||
            act_tag !== 5'd17) begin
            miscompares++;
            $display("FAIL rst_fresh: got v=%b %h/%h want v=1 %h/11", act_out_valid, act_res,
                     act_tag, ref_result(3'b100, a, b));
        end
    endtask

    task automatic test_random();
        logic [2:0]  ops [3];
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [33:0] wx, wy;
        ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b100;
        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 2)];
            a  = $urandom;
            b  = $urandom;
            run_cycle(($urandom_range(0, 9) < 6), op, a, b, 5'($urandom),
                      ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3), 1'b0);
            wx = op[2] ? {2'b00, a} : 34'($signed(a));
            wy = op[2] ? {2'b00, b} : 34'($signed(b));
            vectors++;
            if (act_mul_x !== wx || act_mul_y !== wy) begin
                miscompares++;
                $display("FAIL rnd_operands[%0d]: got %h/%h want %h/%h", i, act_mul_x,
                         act_mul_y, wx, wy);
            end
            vectors++;
            if (act_in_ready !== exp_in_ready || act_out_valid !== exp_out_valid) begin
                miscompares++;
                $display("FAIL rnd_handshake[%0d]: got rdy=%b v=%b want rdy=%b v=%b", i,
                         act_in_ready, act_out_valid, exp_in_ready, exp_out_valid);
            end
            if (exp_out_valid) begin
                vectors++;
                if (act_res !== exp_res || act_tag !== exp_tag) begin
                    miscompares++;
                    $display("FAIL rnd_result[%0d]: got %h/%h want %h/%h", i, act_res,
                             act_tag, exp_res, exp_tag);
                end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_mulh();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
